imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
Shares one synchronous single-port program/data RAM between the CPU fetch stage (port I) and memory stage (port D). At most one access is issued per cycle. A registered owner tag routes each read response back to its requester. A grant-less cycle is the requesting stage's stall. The block sits between the pipelined CPU core and the RAM inside sc_computer.

Parameters:
ADDR_W, 10, word-address width of the shared RAM
DATA_W, 32, data width
D_PRIORITY, 1, 1 = port D fixed priority with starvation guard; 0 = round-robin
STARVE_MAX, 4, consecutive lost-arbitration cycles after which the losing port wins once (D_PRIORITY=1 only)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
i_req  in  1  fetch read request; held with i_addr until i_gnt
i_addr  in  ADDR_W  fetch word address
i_gnt  out  1  fetch access issued this cycle
i_rvalid  out  1  i_rdata valid (one cycle after i_gnt)
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data access issued this cycle
d_rvalid  out  1  d_rdata valid (reads only)
d_rdata  out  DATA_W  data read data
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Grant logic is combinational from req and arbitration state. i_gnt and d_gnt are never both 1. gnt=1 implies mem_en=1 in the same cycle.
- Only one requester: it wins immediately (zero-cycle grant).
- Conflict, D_PRIORITY=1: D wins, unless starve_cnt==STARVE_MAX, in which case I wins and starve_cnt clears.
- starve_cnt increments on each conflict lost by I and clears on any i_gnt. It saturates at STARVE_MAX.
- Conflict, D_PRIORITY=0: the port not granted last wins. The last_gnt register updates on every grant.
- mem_addr/mem_we/mem_wdata come from the winner. I is always a read. With no grant, mem_en=0, mem_we=0, and addr/wdata=0.
- Response tracking: rsp_i and rsp_d are flops set on the cycle after a read grant for I or D respectively. D writes set neither flag.
- i_rvalid=rsp_i and d_rvalid=rsp_d. i_rdata and d_rdata pass mem_rdata through when their rvalid is 1, and are 0 otherwise.
- Fixed latency: a read granted in cycle N returns in cycle N+1. Back-to-back grants give one response per cycle with no bubble.
- A write granted in cycle N completes at that clock edge. A read of the same address in cycle N+1 returns the new data (RAM is write-first irrelevant; accesses are serialized).
- Reset (asynchronous, any time): rsp_i=0, rsp_d=0, starve_cnt=0, last_gnt=I (so the first round-robin conflict goes to D).
- While reset is high, all gnt, rvalid, rdata and mem_* outputs are 0. An in-flight read is dropped, and no rvalid appears after reset deasserts.
- A request dropped before grant is a protocol violation: no state effect, and no assertion is required.

Decomposition:
- Shared package cpu_mem_pkg holds: port-id constants PORT_I=0 and PORT_D=1; the ADDR_W and DATA_W defaults; and the STARVE_MAX default.
- One natural sub-module: arb2_pick, the 2-way priority/round-robin winner select with the starvation counter. The top level keeps the mem mux and the response tags.

Test Plan:
- I-only reads: i_req with i_addr=0x004, 0x005, 0x006 on consecutive cycles -> i_gnt=1 each cycle; i_rvalid on cycles 2..4 with RAM words 4, 5, 6; d_rvalid stays 0.
- D write then read, D_PRIORITY=1: d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF, then a read of 0x010 -> d_gnt on both cycles; d_rvalid=1 with 0xDEADBEEF the cycle after the read; no rvalid for the write.
- Continuous conflict, D_PRIORITY=1, STARVE_MAX=4: i_req and d_req held high for 10 cycles -> grants are D,D,D,D,I,D,D,D,D,I.
- Round-robin, D_PRIORITY=0: both ports request for 6 cycles after reset -> grants are D,I,D,I,D,I; each response is routed to the correct port with one-cycle latency.
- Reset mid-read: D read of 0x020 granted, then reset asserted before the next clock edge -> d_rvalid stays 0 through reset and after release; the first post-reset conflict goes to D in round-robin mode.
- Mixed ports: a D write to 0x030 is followed by an I read of 0x030 the next cycle -> i_rdata equals the written value.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-side memory path: port ids, default widths
// and the arbitration outcome type used by the fetch/data arbiter.
package cpu_mem_pkg;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;
endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the fetch port, data port and shared-RAM port seen by the arbiter.
// slave = arbiter side, master = CPU core plus RAM side.
interface imem_dmem_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb2_pick.sv
// Two-way winner select between fetch (I) and data (D) requests: either D fixed
// priority with a starvation guard for I, or plain alternating round-robin.
module arb2_pick
    import cpu_mem_pkg::*;
#(
    parameter int D_PRIORITY = 1,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clock,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);
    logic conflict;
    logic i_wins_conflict;

    assign conflict = i_req & d_req;

    generate
        if (D_PRIORITY != 0) begin : g_prio
            localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
            logic [CNT_W-1:0] starve_cnt;

            // Once I has lost STARVE_MAX conflicts in a row it takes the next one.
            assign i_wins_conflict = (starve_cnt == CNT_MAX);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    starve_cnt <= '0;
                end else if (i_gnt) begin
                    starve_cnt <= '0;
                end else if (conflict && (starve_cnt != CNT_MAX)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end
        end else begin : g_rr
            logic last_gnt;

            // Starting from PORT_I makes the first conflict after reset go to D.
            assign i_wins_conflict = (last_gnt == PORT_D);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    last_gnt <= PORT_I;
                end else if (i_gnt) begin
                    last_gnt <= PORT_I;
                end else if (d_gnt) begin
                    last_gnt <= PORT_D;
                end
            end
        end
    endgenerate

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (conflict) begin
                i_gnt = i_wins_conflict;
                d_gnt = ~i_wins_conflict;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end
endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous RAM between CPU fetch (I) and memory (D)
// stages; one access per cycle, read data routed back by a registered owner tag.
module imem_dmem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int D_PRIORITY = 1,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clock,
    input  logic                reset,
    imem_dmem_arbiter_if.slave  bus
);
    logic              i_gnt;
    logic              d_gnt;
    gnt_e              winner;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rsp_i;
    logic              rsp_d;

    arb2_pick #(
        .D_PRIORITY (D_PRIORITY),
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clock (clock),
        .reset (reset),
        .i_req (bus.i_req),
        .d_req (bus.d_req),
        .i_gnt (i_gnt),
        .d_gnt (d_gnt)
    );

    always_comb begin
        winner = GNT_NONE;
        if (d_gnt) begin
            winner = GNT_D;
        end else if (i_gnt) begin
            winner = GNT_I;
        end
    end

    // Idle cycles drive zeros so the RAM port is quiet when nobody is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (winner)
            GNT_I: begin
                mem_en   = 1'b1;
                mem_addr = bus.i_addr;
            end
            GNT_D: begin
                mem_en    = 1'b1;
                mem_we    = bus.d_we;
                mem_addr  = bus.d_addr;
                mem_wdata = bus.d_wdata;
            end
            default: ;
        endcase
    end

    // Owner tags for the read issued last cycle; writes produce no response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_i <= 1'b0;
            rsp_d <= 1'b0;
        end else begin
            rsp_i <= i_gnt;
            rsp_d <= d_gnt & ~bus.d_we;
        end
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_rvalid  = rsp_i;
    assign bus.d_rvalid  = rsp_d;
    assign bus.i_rdata   = rsp_i ? bus.mem_rdata : '0;
    assign bus.d_rdata   = rsp_d ? bus.mem_rdata : '0;
endmodule
